// File: rtl/input_debouncer_pkg.sv
// rtl/input_debouncer_pkg.sv - shared state encodings and helpers for the input debouncer
package input_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_ZERO  = 2'b00,
        ST_WAIT1 = 2'b01,
        ST_ONE   = 2'b10,
        ST_WAIT0 = 2'b11
    } db_state_t;

    // The debounced level is high while settled high or while qualifying a fall.
    function automatic logic state_is_high(input db_state_t st);
        return (st == ST_ONE) || (st == ST_WAIT0);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one-bit synchronizer, debounce FSM, stability counter and edge ticks
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int CNT_W     = 20,
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db,
    output logic rise_tick,
    output logic fall_tick
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             s;
    db_state_t        state_q;
    db_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_load;
    logic             cnt_dec;
    logic             rise_d;
    logic             fall_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], sw};
        end
    end

    assign s = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_ZERO;
            cnt_q     <= '0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            state_q   <= state_d;
            rise_tick <= rise_d;
            fall_tick <= fall_d;
            if (cnt_load) begin
                cnt_q <= CNT_LOAD;
            end else if (cnt_dec && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        case (state_q)
            ST_ZERO: begin
                if (s) begin
                    state_d  = ST_WAIT1;
                    cnt_load = 1'b1;
                end
            end
            ST_WAIT1: begin
                if (!s) begin
                    state_d = ST_ZERO;
                end else if (cnt_q == '0) begin
                    state_d = ST_ONE;
                    rise_d  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_ONE: begin
                if (!s) begin
                    state_d  = ST_WAIT0;
                    cnt_load = 1'b1;
                end
            end
            ST_WAIT0: begin
                if (s) begin
                    state_d = ST_ONE;
                end else if (cnt_q == '0) begin
                    state_d = ST_ZERO;
                    fall_d  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_d = ST_ZERO;
        endcase
    end

    always_comb begin
        db = state_is_high(state_q);
    end

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - N_CH independent debounced channels with rise/fall ticks
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int N_CH      = 3,
    parameter int CNT_W     = 20,
    parameter int DB_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw_in,
    output logic [N_CH-1:0] db_out,
    output logic [N_CH-1:0] rise_tick,
    output logic [N_CH-1:0] fall_tick
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .CNT_W     (CNT_W),
            .DB_CYCLES (DB_CYCLES)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .sw        (sw_in[i]),
            .db        (db_out[i]),
            .rise_tick (rise_tick[i]),
            .fall_tick (fall_tick[i])
        );
    end

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed self-checking bench for input_debouncer with DB_CYCLES=4
module tb_input_debouncer;

    logic       clk;
    logic       reset;
    logic [2:0] sw_in;
    logic [2:0] db_out;
    logic [2:0] rise_tick;
    logic [2:0] fall_tick;
    logic       y;

    int errors;
    int checks;

    input_debouncer #(
        .N_CH      (3),
        .CNT_W     (20),
        .DB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_in     (sw_in),
        .db_out    (db_out),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    assign y = &db_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int hits;
        int rises;
        int first_at;
        int toggles;
        logic y_prev;
        logic [2:0] pat;

        errors = 0;
        checks = 0;
        reset  = 1'b1;
        sw_in  = 3'b111;

        // 1. reset holds everything low, then release with pins high
        step_n(3);
        check("t1_reset_db", 32'(db_out), 32'h0);
        check("t1_reset_rise", 32'(rise_tick), 32'h0);
        check("t1_reset_fall", 32'(fall_tick), 32'h0);
        reset = 1'b0;
        step_n(6);
        check("t1_db_edge5", 32'(db_out), 32'h0);
        step();
        check("t1_db_edge6", 32'(db_out), 32'h7);
        check("t1_rise_edge6", 32'(rise_tick), 32'h7);
        step();
        check("t1_rise_edge7", 32'(rise_tick), 32'h0);

        sw_in = 3'b000;
        step_n(6);
        check("t1_fall_db_edge5", 32'(db_out), 32'h7);
        step();
        check("t1_fall_db_edge6", 32'(db_out), 32'h0);
        check("t1_fall_tick_edge6", 32'(fall_tick), 32'h7);
        step();
        check("t1_fall_tick_edge7", 32'(fall_tick), 32'h0);

        // 2. three-cycle glitch on ch0 is rejected
        hits = 0;
        sw_in[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            hits += int'(db_out[0]) + int'(rise_tick[0]);
        end
        sw_in[0] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            hits += int'(db_out[0]) + int'(rise_tick[0]);
        end
        check("t2_glitch_hits", 32'(hits), 32'h0);

        // 3. clean press and release on ch1
        sw_in[1] = 1'b1;
        step_n(6);
        check("t3_db_edge5", 32'(db_out), 32'h0);
        step();
        check("t3_db_edge6", 32'(db_out), 32'h2);
        check("t3_rise_edge6", 32'(rise_tick), 32'h2);
        step();
        check("t3_rise_edge7", 32'(rise_tick), 32'h0);
        step_n(4);
        sw_in[1] = 1'b0;
        step_n(6);
        check("t3_rel_db_edge5", 32'(db_out), 32'h2);
        step();
        check("t3_rel_db_edge6", 32'(db_out), 32'h0);
        check("t3_fall_edge6", 32'(fall_tick), 32'h2);
        step();
        check("t3_fall_edge7", 32'(fall_tick), 32'h0);

        // 4. bouncing press on ch2: 1,0,1,0 then steady 1
        rises = 0;
        pat = 3'b101;
        for (int k = 0; k < 4; k++) begin
            sw_in[2] = pat[k % 2];
            step();
            rises += int'(rise_tick[2]);
        end
        sw_in[2] = 1'b1;
        first_at = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (rise_tick[2]) begin
                rises++;
                if (first_at == 0) first_at = k;
            end
        end
        check("t4_rise_count", 32'(rises), 32'h1);
        check("t4_rise_edge", 32'(first_at), 32'h7);
        check("t4_db", 32'(db_out), 32'h4);

        // 5. reset two cycles into a ch0 qualification clears outputs without a clock
        sw_in[0] = 1'b1;
        step_n(4);
        reset = 1'b1;
        #1;
        check("t5_async_db", 32'(db_out), 32'h0);
        check("t5_async_rise", 32'(rise_tick), 32'h0);
        step();
        reset = 1'b0;
        step_n(6);
        check("t5_db_edge5", 32'(db_out), 32'h0);
        step();
        check("t5_db_edge6", 32'(db_out), 32'h5);
        check("t5_rise_edge6", 32'(rise_tick), 32'h5);

        // 6. downstream AND only rises once all channels qualify; short glitches never toggle it
        sw_in[1] = 1'b1;
        step_n(6);
        check("t6_y_edge5", 32'(y), 32'h0);
        step();
        check("t6_y_edge6", 32'(y), 32'h1);
        toggles = 0;
        y_prev = y;
        for (int ch = 0; ch < 3; ch++) begin
            sw_in[ch] = 1'b0;
            step();
            if (y !== y_prev) toggles++;
            y_prev = y;
            step();
            if (y !== y_prev) toggles++;
            y_prev = y;
            sw_in[ch] = 1'b1;
            for (int k = 0; k < 10; k++) begin
                step();
                if (y !== y_prev) toggles++;
                y_prev = y;
            end
        end
        check("t6_y_toggles", 32'(toggles), 32'h0);
        check("t6_y_final", 32'(y), 32'h1);
        check("t6_no_fall", 32'(fall_tick), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
